act_pingpong_buffer: RTL
========================

# act_pingpong_buffer

Upstream input stage for the fully connected `layer` neurons. It receives activations as a serial WIDTH-bit stream with valid/ready and assembles them into IN-element vectors. Each vector is presented in parallel on `x[0:IN-1]`, which drives the combinational multiply/adder-tree/ReLU neuron array. Two banks alternate (ping-pong), so loading the next vector overlaps with the current vector being consumed.

## Interface
- `WIDTH`, 8, activation element width; matches the neuron `WIDTH`.
- `IN`, 128, elements per vector; matches the neuron `IN`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `s_data` input, WIDTH bits: stream element.
- `s_valid` input, 1 bit: `s_data` is valid.
- `s_last` input, 1 bit: this element is the final element of its vector.
- `s_ready` output, 1 bit: the block accepts an element this cycle.
- `x` output, `[WIDTH-1:0] x[0:IN-1]`: current vector, connected directly to the neuron `x`.
- `x_valid` output, 1 bit: `x` is complete and stable.
- `x_ready` input, 1 bit: consumer has captured the neuron results; release the vector.
- `len_err` output, 1 bit: one-cycle pulse when vector length and `s_last` disagree.

## Operation
- **Storage:** two banks of IN×WIDTH registers. Each bank has a state: EMPTY → FILLING → FULL → EMPTY.
- **Write pointers:**
  - `wr_bank` selects the bank being written.
  - `wr_idx` runs 0..IN-1, width `$clog2(IN)`.
- **Write rules:**
  - `s_ready = rst_n & (state[wr_bank] != FULL)`.
  - Accept when `s_valid & s_ready`: write `bank[wr_bank][wr_idx]`, then increment `wr_idx`.
  - The first accept into an EMPTY bank moves it to FILLING.
- **Vector close:** on an accepted beat with `s_last`, or with `wr_idx == IN-1`:
  - bank → FULL, `wr_idx` ← 0, `wr_bank` toggles.
- **Length errors:** `len_err` pulses the cycle after the close beat in either case:
  - `s_last` with `wr_idx < IN-1` (early close; unwritten entries stay 0);
  - `wr_idx == IN-1` without `s_last` (forced close).
- **Read side:**
  - `rd_bank` selects the presented bank; `x = bank[rd_bank]` and `x_valid = (state[rd_bank] == FULL)`.
  - On `x_valid & x_ready`: clear every entry of `bank[rd_bank]` to 0, set the bank to EMPTY, toggle `rd_bank`.
- **Simultaneous events:**
  - A write close on one bank and a read release on the other in the same cycle both take effect.
  - Read and write never target the same bank in one cycle, because a FULL bank is never written.
- **Combinational paths:** none from `x_ready` to `s_ready`, and none from `s_valid` to `x_valid`.
- **Arithmetic:** none. Data passes bit-exact; there is no sign handling.

## Timing
- **Reset (async assert, sync deassert):**
  - all bank entries 0; both banks EMPTY;
  - `wr_bank = rd_bank = 0`, `wr_idx = 0`;
  - `x_valid = 0`, `len_err = 0`, `s_ready = 0` while `rst_n` is low and 1 on the first cycle after.
- **Reset mid-operation:** any partial vector and any FULL vector are discarded.
- **Fill latency:** `x_valid` rises in the cycle after the edge that accepts the closing beat.
- **Neuron output:** valid combinationally in the same cycles as `x_valid`; the consumer registers it on the `x_valid & x_ready` edge.
- **Throughput:** one element per cycle, sustained indefinitely, provided each vector is released within IN cycles of `x_valid`.
- **Both banks FULL:** `s_ready` stays 0 until the release edge; it rises the next cycle.
- **`x` stability:** `x` is stable from `x_valid` rise until the release edge. `x` then shows the other bank, which may already be FULL (back-to-back `x_valid`).

## Structure
- Shared package `cnn_pkg`: `bank_state_t` enum (EMPTY, FILLING, FULL).
- One sub-module, `act_bank`:
  - IN×WIDTH register file with indexed write enable and synchronous clear-all;
  - instantiated twice.
- Top level holds the pointers, state, handshake and `len_err` logic.

## Test plan
- **Single vector:** after reset, send 128 beats `s_data = i` with `s_last` on beat 127. Require `x_valid` the next cycle and `x[0] = 0`, `x[127] = 127`; require `x` to hold while `x_ready = 0`.
- **Back-pressure:** send 3 vectors with `x_ready = 0`. Require `s_ready` to drop after the second close; assert `x_ready` for one cycle; require `x` to switch to vector 2 and `s_ready` to rise next cycle.
- **Streaming:** send continuous `s_valid` with `x_ready` pulsed once per vector. Require 10 vectors with zero stalls and data bit-exact.
- **Early `s_last`:** `s_last` at beat 9. Require `len_err` for one cycle, `x[0..9]` equal to the data and `x[10..127] = 0`. Missing `s_last` at beat 127 also requires a `len_err` pulse.
- **Reset mid-fill:** drop `rst_n` at beat 60 of a fill while the other bank is FULL. Require `x_valid = 0` immediately and all `x = 0`; a new vector afterwards starts at index 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Types shared across the CNN datapath blocks.
package cnn_pkg;
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;
endpackage

// File: rtl/act_bank.sv
// One activation bank: IN x WIDTH registers with indexed write and synchronous clear-all.
// Clear has priority over write; the top never requests both on the same bank.
module act_bank #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int IW    = $clog2(IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [IW-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o [0:IN-1]
);
  logic [WIDTH-1:0] mem_q [0:IN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < IN; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign data_o = mem_q;
endmodule

// File: rtl/act_pingpong_buffer.sv
// Serial-to-parallel ping-pong activation buffer: x_valid rises the cycle after the closing beat.
// s_ready drops only while the write bank is still FULL; both handshakes are decoupled by registered state.
module act_pingpong_buffer
  import cnn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             len_err
);
  localparam int            IW       = $clog2(IN);
  localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);

  bank_state_t      state_q [2];
  bank_state_t      state_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic             len_err_q, len_err_d;
  logic             accept, at_last, close, rd_release;
  logic [1:0]       bank_we, bank_clr;
  logic [WIDTH-1:0] bank_dat [2][0:IN-1];

  assign s_ready    = rst_n & (state_q[wr_bank_q] != FULL);
  assign x_valid    = (state_q[rd_bank_q] == FULL);
  assign at_last    = (wr_idx_q == LAST_IDX);
  assign accept     = s_valid & s_ready;
  assign close      = accept & (s_last | at_last);
  assign rd_release = x_valid & x_ready;
  assign len_err    = len_err_q;

  // Write and read always target different banks, so both updates can apply together.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    len_err_d  = accept & (s_last ^ at_last);
    bank_we    = '0;
    bank_clr   = '0;
    if (accept) begin
      bank_we[wr_bank_q] = 1'b1;
      if (close) begin
        state_d[wr_bank_q] = FULL;
        wr_idx_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = FILLING;
        wr_idx_d           = wr_idx_q + 1'b1;
      end
    end
    if (rd_release) begin
      state_d[rd_bank_q]  = EMPTY;
      bank_clr[rd_bank_q] = 1'b1;
      rd_bank_d           = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      len_err_q  <= len_err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_bank #(.WIDTH(WIDTH), .IN(IN), .IW(IW)) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (bank_we[b]),
      .wr_idx_i (wr_idx_q),
      .wr_dat_i (s_data),
      .clr_i    (bank_clr[b]),
      .data_o   (bank_dat[b])
    );
  end

  always_comb begin
    for (int i = 0; i < IN; i++) x[i] = rd_bank_q ? bank_dat[1][i] : bank_dat[0][i];
  end
endmodule
